// File: rtl/pc_ctrl_pkg.sv
// Shared types and constants for the instruction-fetch controller.
package pc_ctrl_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_FLUSH = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
  } fifo_entry_t;

  // Branch immediates are in halfwords; JALR targets drop bit 0.
  function automatic logic [XLEN-1:0] redirect_target(
    input logic            br_taken,
    input logic [XLEN-1:0] br_pc,
    input logic [XLEN-1:0] br_imm,
    input logic [XLEN-1:0] jalr_tgt
  );
    if (br_taken) begin
      return br_pc + {br_imm[XLEN-2:0], 1'b0};
    end
    return {jalr_tgt[XLEN-1:1], 1'b0};
  endfunction

endpackage

// File: rtl/pc_inst_fifo.sv
// Two-entry {inst, pc} buffer between memory return and the decode stage.
module pc_inst_fifo
  import pc_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  logic        pop,
  input  logic        flush,
  input  fifo_entry_t wdata,
  output logic [1:0]  count,
  output fifo_entry_t head
);

  fifo_entry_t mem_q [2];
  fifo_entry_t mem_d [2];
  logic        rd_ptr_q, rd_ptr_d;
  logic        wr_ptr_q, wr_ptr_d;
  logic [1:0]  count_q, count_d;
  logic        do_push, do_pop;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    do_push  = push && ((count_q != 2'd2) || pop);
    do_pop   = pop && (count_q != 2'd0);
    if (flush) begin
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Instruction fetch sequencer: one outstanding request, 2-deep return buffer.
// state | meaning
// IDLE  | no request; waiting for buffer space
// FETCH | request at req_addr outstanding, data will be kept
// FLUSH | request outstanding but redirected; its data is dropped
module pc_fetch_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            I_ready,
  input  logic [XLEN-1:0] I_rdata,
  output logic            I_ren,
  output logic [XLEN-1:0] I_addr,
  input  logic            Br_taken,
  input  logic [XLEN-1:0] Br_pc,
  input  logic [XLEN-1:0] Br_imm,
  input  logic            Jalr_en,
  input  logic [XLEN-1:0] Jalr_tgt,
  input  logic            Stall,
  output logic            Inst_valid,
  output logic [XLEN-1:0] Inst,
  output logic [XLEN-1:0] Inst_pc
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] req_addr_q, req_addr_d;
  logic [1:0]      fifo_count;
  fifo_entry_t     fifo_head;
  fifo_entry_t     fifo_wdata;
  logic            redirect;
  logic [XLEN-1:0] target;
  logic            push, pop, space;
  logic [2:0]      occ_next;

  assign redirect   = Br_taken | Jalr_en;
  assign target     = redirect_target(Br_taken, Br_pc, Br_imm, Jalr_tgt);
  assign Inst_valid = (fifo_count != 2'd0);
  assign pop        = Inst_valid & ~Stall;
  assign push       = (state_q == ST_FETCH) & I_ready & ~redirect;
  // Issue only if the data of a new request is guaranteed a slot.
  assign occ_next   = {1'b0, fifo_count} + {2'b00, push} - {2'b00, pop};
  assign space      = (occ_next <= 3'd1);
  assign fifo_wdata = '{inst: I_rdata, pc: req_addr_q};

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    if (redirect) begin
      pc_d = target;
      if ((state_q == ST_IDLE) || I_ready) begin
        req_addr_d = target;
        state_d    = ST_FETCH;
      end else begin
        state_d = ST_FLUSH;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (space) begin
            req_addr_d = pc_q;
            state_d    = ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (I_ready) begin
            pc_d = req_addr_q + 32'd4;
            if (space) begin
              req_addr_d = req_addr_q + 32'd4;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
        ST_FLUSH: begin
          if (I_ready) begin
            req_addr_d = pc_q;
            state_d    = ST_FETCH;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC;
      req_addr_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
    end
  end

  pc_inst_fifo u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .wdata (fifo_wdata),
    .count (fifo_count),
    .head  (fifo_head)
  );

  assign I_ren   = (state_q == ST_FETCH) || (state_q == ST_FLUSH);
  assign I_addr  = req_addr_q;
  assign Inst    = fifo_head.inst;
  assign Inst_pc = fifo_head.pc;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed and random checks of pc_fetch_ctrl against a program-order stream model.
module tb_pc_fetch_ctrl;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk;
  logic        rst_n;
  logic        I_ready;
  logic [31:0] I_rdata;
  logic        I_ren;
  logic [31:0] I_addr;
  logic        Br_taken;
  logic [31:0] Br_pc;
  logic [31:0] Br_imm;
  logic        Jalr_en;
  logic [31:0] Jalr_tgt;
  logic        Stall;
  logic        Inst_valid;
  logic [31:0] Inst;
  logic [31:0] Inst_pc;

  int          checks;
  int          failures;
  logic [31:0] exp_pc;
  bit          expect_empty;
  bit          hold;
  logic [31:0] hold_addr;

  pc_fetch_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .I_ready    (I_ready),
    .I_rdata    (I_rdata),
    .I_ren      (I_ren),
    .I_addr     (I_addr),
    .Br_taken   (Br_taken),
    .Br_pc      (Br_pc),
    .Br_imm     (Br_imm),
    .Jalr_en    (Jalr_en),
    .Jalr_tgt   (Jalr_tgt),
    .Stall      (Stall),
    .Inst_valid (Inst_valid),
    .Inst       (Inst),
    .Inst_pc    (Inst_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] model_target();
    if (Br_taken) return Br_pc + Br_imm * 32'd2;
    return Jalr_tgt & 32'hFFFF_FFFE;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Model: delivered instructions must form the program-order stream from
  // the last reset or redirect, each carrying memory's word for its pc.
  task automatic tick();
    @(negedge clk);
    if (expect_empty) check("flush_empty", {31'd0, Inst_valid}, 32'd0);
    expect_empty = 1'b0;
    if (Br_taken || Jalr_en) begin
      exp_pc       = model_target();
      expect_empty = 1'b1;
    end else if (Inst_valid && !Stall) begin
      check("inst_pc", Inst_pc, exp_pc);
      check("inst_data", Inst, memf(exp_pc));
      exp_pc = exp_pc + 32'd4;
    end
    hold      = I_ren && !I_ready;
    hold_addr = I_addr;
    @(posedge clk);
    #1;
    if (hold) check("addr_hold", I_addr, hold_addr);
    hold     = 1'b0;
    Br_taken = 1'b0;
    Jalr_en  = 1'b0;
    I_rdata  = memf(I_addr);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_ren", {31'd0, I_ren}, 32'd0);
    check("rst_valid", {31'd0, Inst_valid}, 32'd0);
    check("rst_addr", I_addr, RST_PC);
    exp_pc       = RST_PC;
    expect_empty = 1'b0;
    hold         = 1'b0;
    Br_taken     = 1'b0;
    Jalr_en      = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("boot_ren", {31'd0, I_ren}, 32'd1);
    check("boot_addr", I_addr, RST_PC);
    check("boot_valid", {31'd0, Inst_valid}, 32'd0);
    I_rdata = memf(I_addr);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    I_ready  = 1'b0;
    I_rdata  = memf(RST_PC);
    Br_taken = 1'b0;
    Br_pc    = '0;
    Br_imm   = '0;
    Jalr_en  = 1'b0;
    Jalr_tgt = '0;
    Stall    = 1'b0;
    #2;

    // Back-to-back streaming
    I_ready = 1'b1;
    do_reset();
    for (int k = 1; k <= 3; k++) begin
      tick();
      check("b2b_addr", I_addr, 32'd4 * k);
      check("b2b_pc", Inst_pc, 32'd4 * (k - 1));
    end

    // Stall fills the buffer and parks the fetcher
    Stall = 1'b1;
    do_reset();
    for (int k = 0; k < 5; k++) tick();
    check("stall_ren", {31'd0, I_ren}, 32'd0);
    check("stall_valid", {31'd0, Inst_valid}, 32'd1);
    check("stall_pc", Inst_pc, 32'd0);
    Stall = 1'b0;
    tick();
    check("resume_pc", Inst_pc, 32'd4);
    check("resume_addr", I_addr, 32'd8);
    for (int k = 0; k < 3; k++) tick();

    // Branch while the request is pending
    I_ready = 1'b0;
    tick();
    check("wait_ren", {31'd0, I_ren}, 32'd1);
    Br_taken = 1'b1;
    Br_pc    = 32'h20;
    Br_imm   = 32'h8;
    tick();
    check("flush_ren", {31'd0, I_ren}, 32'd1);
    I_ready = 1'b1;
    tick();
    check("br_addr", I_addr, 32'h30);
    check("br_valid", {31'd0, Inst_valid}, 32'd0);
    tick();
    check("br_inst_pc", Inst_pc, 32'h30);

    // Simultaneous branch and JALR: branch wins
    Br_taken = 1'b1;
    Br_pc    = 32'h40;
    Br_imm   = 32'h2;
    Jalr_en  = 1'b1;
    Jalr_tgt = 32'h101;
    tick();
    check("both_addr", I_addr, 32'h44);
    check("both_valid", {31'd0, Inst_valid}, 32'd0);
    tick();
    check("both_inst_pc", Inst_pc, 32'h44);

    // Address wrap
    Jalr_en  = 1'b1;
    Jalr_tgt = 32'hFFFF_FFFC;
    tick();
    check("wrap_addr0", I_addr, 32'hFFFF_FFFC);
    tick();
    check("wrap_addr1", I_addr, 32'h0);
    check("wrap_pc", Inst_pc, 32'hFFFF_FFFC);
    tick();

    // Reset with a request outstanding
    do_reset();
    tick();
    tick();
    check("pre_rst_addr", I_addr, 32'h8);
    check("pre_rst_ren", {31'd0, I_ren}, 32'd1);
    do_reset();
    tick();
    check("post_rst_pc", Inst_pc, RST_PC);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      Stall   = ($urandom % 4) == 0;
      I_ready = I_ren && (($urandom % 3) != 0);
      if (($urandom % 20) == 0) begin
        case ($urandom % 3)
          0: Br_taken = 1'b1;
          1: Jalr_en = 1'b1;
          default: begin
            Br_taken = 1'b1;
            Jalr_en  = 1'b1;
          end
        endcase
        Br_pc    = $urandom & 32'hFFFF_FFFC;
        Br_imm   = 32'($urandom_range(0, 255)) - 32'd128;
        Jalr_tgt = $urandom;
      end
      if (($urandom % 500) == 0) begin
        do_reset();
      end else begin
        tick();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
